fir_engine_param: RTL and testbench

//  Parametrised FIR accelerator: AXI4-Lite for control/coefficients, AXI-Stream in (ss_*) and out (sm_*).

---
 rtl/fir_engine_param.sv | 211 +++++++++++++++++++++
 tb/tb_fir_engine_param.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_engine_param.sv
// Parametrised FIR engine: AXI-Lite control and coefficients,
// AXI-Stream samples in and results out, runtime tap count.
module fir_engine_param #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int pTAP_MAX    = 32
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   arvalid,
  output logic                   arready,
  input  logic [pADDR_WIDTH-1:0] araddr,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [pDATA_WIDTH-1:0] rdata,
  input  logic                   ss_tvalid,
  output logic                   ss_tready,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  input  logic                   ss_tlast,
  output logic                   sm_tvalid,
  input  logic                   sm_tready,
  output logic [pDATA_WIDTH-1:0] sm_tdata,
  output logic                   sm_tlast
);

  localparam int TW = $clog2(pTAP_MAX + 1);
  localparam int KW = (pTAP_MAX > 1) ? $clog2(pTAP_MAX) : 1;
  localparam int AW = pADDR_WIDTH;
  localparam int DW = pDATA_WIDTH;

  localparam logic [AW-1:0] A_CTRL = '0;
  localparam logic [AW-1:0] A_LEN  = AW'(16);
  localparam logic [AW-1:0] A_TAP  = AW'(20);
  localparam logic [AW-1:0] C_LO   = AW'(128);
  localparam logic [AW-1:0] C_HI   = AW'(128 + 4 * pTAP_MAX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_IN,
    S_MAC,
    S_OUT
  } state_t;

  state_t        state;
  logic [DW-1:0] coef [pTAP_MAX];
  logic [DW-1:0] xh   [pTAP_MAX];
  logic [DW-1:0] data_length;
  logic [DW-1:0] cnt;
  logic [DW-1:0] acc;
  logic [DW-1:0] prod;
  logic [DW-1:0] rd_val;
  logic [TW-1:0] tap_num;
  logic [TW-1:0] taps;
  logic [TW-1:0] k;
  logic          ap_done;
  logic          ap_idle;
  logic          rd_ctrl;
  logic          wr_fire;
  logic          done_clr;
  logic          unused_tlast;

  function automatic logic is_coef(
    input logic [AW-1:0] a
  );
    return (a >= C_LO) && (a < C_HI)
      && (a[1:0] == 2'b00);
  endfunction

  function automatic logic [KW-1:0] cidx(
    input logic [AW-1:0] a
  );
    return KW'((a - C_LO) >> 2);
  endfunction

  assign unused_tlast = ss_tlast;
  assign ap_idle  = (state == S_IDLE);
  assign wready   = awready;
  assign wr_fire  = awready && awvalid && wvalid;
  assign done_clr = rvalid && rready && rd_ctrl;
  assign taps     = (tap_num == '0)
    ? TW'(pTAP_MAX) : tap_num;

  // low half of the full 2W product is all the wrapped result needs
  assign prod = coef[k[KW-1:0]] * xh[k[KW-1:0]];

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      (araddr == A_CTRL):
        rd_val = DW'({ap_idle, ap_done, 1'b0});
      (araddr == A_LEN): rd_val = data_length;
      (araddr == A_TAP): rd_val = DW'(tap_num);
      is_coef(araddr):
        rd_val = coef[cidx(araddr)];
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      awready <= 1'b0;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rd_ctrl <= 1'b0;
    end else begin
      awready <= awvalid && wvalid && !awready;
      arready <= arvalid && !arready && !rvalid;
      if (arready && arvalid) begin
        rvalid  <= 1'b1;
        rdata   <= rd_val;
        rd_ctrl <= (araddr == A_CTRL);
      end else if (rvalid && rready) begin
        rvalid  <= 1'b0;
        rd_ctrl <= 1'b0;
      end
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state       <= S_IDLE;
      ap_done     <= 1'b0;
      data_length <= '0;
      tap_num     <= '0;
      cnt         <= '0;
      acc         <= '0;
      k           <= '0;
      ss_tready   <= 1'b0;
      sm_tvalid   <= 1'b0;
      sm_tdata    <= '0;
      sm_tlast    <= 1'b0;
      for (int i = 0; i < pTAP_MAX; i++) begin
        coef[i] <= '0;
        xh[i]   <= '0;
      end
    end else begin
      if (done_clr) ap_done <= 1'b0;
      if (wr_fire && ap_idle) begin
        if (awaddr == A_CTRL && wdata[0]) begin
          for (int i = 0; i < pTAP_MAX; i++)
            xh[i] <= '0;
          cnt     <= '0;
          ap_done <= 1'b0;
          if (data_length == '0) begin
            ap_done <= 1'b1;
          end else begin
            state     <= S_IN;
            ss_tready <= 1'b1;
          end
        end
        if (awaddr == A_LEN) data_length <= wdata;
        if (awaddr == A_TAP) begin
          if (wdata == '0 || wdata > DW'(pTAP_MAX))
            tap_num <= TW'(pTAP_MAX);
          else
            tap_num <= TW'(wdata);
        end
        if (is_coef(awaddr))
          coef[cidx(awaddr)] <= wdata;
      end
      unique case (state)
        S_IDLE: ;
        S_IN: begin
          if (ss_tvalid) begin
            xh[0] <= ss_tdata;
            for (int i = 1; i < pTAP_MAX; i++)
              xh[i] <= xh[i-1];
            ss_tready <= 1'b0;
            acc       <= '0;
            k         <= '0;
            state     <= S_MAC;
          end
        end
        S_MAC: begin
          acc <= acc + prod;
          k   <= k + TW'(1);
          if (k == taps - TW'(1)) begin
            sm_tdata  <= acc + prod;
            sm_tvalid <= 1'b1;
            sm_tlast  <=
              (cnt + DW'(1) == data_length);
            state     <= S_OUT;
          end
        end
        S_OUT: begin
          if (sm_tready) begin
            sm_tvalid <= 1'b0;
            sm_tlast  <= 1'b0;
            cnt       <= cnt + DW'(1);
            if (cnt + DW'(1) == data_length) begin
              state   <= S_IDLE;
              ap_done <= 1'b1;
            end else begin
              state     <= S_IN;
              ss_tready <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_engine_param.sv
// Bench for fir_engine_param: directed register steps plus
// random streams checked against an arithmetic FIR model.
module tb_fir_engine_param;

  localparam int LIM = 500;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        awvalid = 0, wvalid = 0, arvalid = 0;
  logic        rready = 0, ss_tvalid = 0, ss_tlast = 0;
  logic        sm_tready = 0;
  logic [11:0] awaddr = '0, araddr = '0;
  logic [31:0] wdata = '0, ss_tdata = '0;
  logic        awready, wready, arready, rvalid;
  logic        ss_tready, sm_tvalid, sm_tlast;
  logic [31:0] rdata, sm_tdata;

  int n_assert = 0;
  int n_fail = 0;
  int xs [400];
  int cf [32];
  int taps;
  int dlen;

  fir_engine_param #(
    .pADDR_WIDTH(12),
    .pDATA_WIDTH(32),
    .pTAP_MAX(32)
  ) dut (
    .axis_clk(clk),
    .axis_rst_n(rst_n),
    .awvalid(awvalid),
    .awready(awready),
    .awaddr(awaddr),
    .wvalid(wvalid),
    .wready(wready),
    .wdata(wdata),
    .arvalid(arvalid),
    .arready(arready),
    .araddr(araddr),
    .rvalid(rvalid),
    .rready(rready),
    .rdata(rdata),
    .ss_tvalid(ss_tvalid),
    .ss_tready(ss_tready),
    .ss_tdata(ss_tdata),
    .ss_tlast(ss_tlast),
    .sm_tvalid(sm_tvalid),
    .sm_tready(sm_tready),
    .sm_tdata(sm_tdata),
    .sm_tlast(sm_tlast)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h",
             tag, obs, exp);
    end
  endtask

  // y[n] = sum c[k]*x[n-k], wrapped to 32 bits
  function automatic logic [31:0] ref_y(int n);
    longint s = 0;
    for (int j = 0; j < taps; j++)
      if (n - j >= 0)
        s += longint'(cf[j]) * longint'(xs[n-j]);
    return s[31:0];
  endfunction

  task automatic lw(
    input logic [11:0] a,
    input logic [31:0] d
  );
    int t = 0;
    @(negedge clk);
    awaddr = a; wdata = d;
    awvalid = 1; wvalid = 1;
    while (!(awready && wready) && t < LIM) begin
      @(negedge clk); t++;
    end
    check("aw_wait", 32'(t < LIM), 1);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
  endtask

  task automatic lr(
    input  logic [11:0] a,
    output logic [31:0] d
  );
    int t = 0;
    @(negedge clk);
    araddr = a; arvalid = 1;
    while (!arready && t < LIM) begin
      @(negedge clk); t++;
    end
    @(posedge clk); #1 arvalid = 0;
    @(negedge clk);
    while (!rvalid && t < LIM) begin
      @(negedge clk); t++;
    end
    check("ar_wait", 32'(t < LIM), 1);
    d = rdata;
    rready = 1;
    @(posedge clk); #1 rready = 0;
  endtask

  task automatic rd_chk(
    input string tag,
    input logic [11:0] a,
    input logic [31:0] exp
  );
    logic [31:0] d;
    lr(a, d);
    check(tag, d, exp);
  endtask

  task automatic prog(input int tw, input int len);
    lw(12'h010, 32'(len));
    lw(12'h014, 32'(tw));
    for (int j = 0; j < 32; j++)
      lw(12'(128 + 4 * j), 32'(cf[j]));
    taps = tw; dlen = len;
  endtask

  task automatic run(
    input int n,
    input int stall_at,
    input int busy_at,
    input int abort_at
  );
    int t;
    logic [31:0] held;
    for (int i = 0; i < n; i++) begin
      if (i == busy_at) begin
        lw(12'h080, 32'd99);
        lw(12'h010, 32'd5);
        lw(12'h000, 32'd1);
      end
      repeat ($urandom_range(0, 1)) @(negedge clk);
      @(negedge clk);
      ss_tvalid = 1; ss_tdata = xs[i]; t = 0;
      while (!ss_tready && t < LIM) begin
        @(negedge clk); t++;
      end
      @(posedge clk); #1 ss_tvalid = 0;
      if (i == abort_at) return;
      @(negedge clk);
      while (!sm_tvalid && t < LIM) begin
        @(negedge clk); t++;
      end
      check("stream_wait", 32'(t < LIM), 1);
      if (i == stall_at) begin
        held = sm_tdata;
        repeat (20) begin
          @(negedge clk);
          check("stall_valid", 32'(sm_tvalid), 1);
          check("stall_data", sm_tdata, held);
          check("stall_ss", 32'(ss_tready), 0);
        end
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      check($sformatf("y[%0d]", i), sm_tdata, ref_y(i));
      check($sformatf("tlast[%0d]", i),
            32'(sm_tlast), 32'(i == dlen - 1));
      sm_tready = 1;
      @(posedge clk); #1 sm_tready = 0;
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_awready", 32'(awready), 0);
    check("rst_arready", 32'(arready), 0);
    check("rst_rvalid", 32'(rvalid), 0);
    check("rst_rdata", rdata, 0);
    check("rst_ss_tready", 32'(ss_tready), 0);
    check("rst_sm_tvalid", 32'(sm_tvalid), 0);
    check("rst_sm_tdata", sm_tdata, 0);
    check("rst_sm_tlast", 32'(sm_tlast), 0);
    @(negedge clk) rst_n = 1;
    rd_chk("ctrl_reset", 12'h000, 32'h4);
    rd_chk("tap_reset", 12'h014, 0);

    lw(12'h014, 0);
    rd_chk("tap_zero", 12'h014, 32);
    lw(12'h014, 40);
    rd_chk("tap_big", 12'h014, 32);
    rd_chk("unmapped_40", 12'h040, 0);
    rd_chk("unmapped_100", 12'h100, 0);

    for (int j = 0; j < 32; j++)
      cf[j] = int'($urandom_range(0, 2000)) - 1000;
    prog(32, 400);
    rd_chk("len_rb", 12'h010, 400);
    rd_chk("tap_rb", 12'h014, 32);
    for (int j = 0; j < 32; j++)
      rd_chk($sformatf("coef_rb[%0d]", j),
             12'(128 + 4 * j), 32'(cf[j]));
    rd_chk("ctrl_idle", 12'h000, 32'h4);

    for (int i = 0; i < 400; i++) xs[i] = int'($urandom);
    lw(12'h000, 1);
    run(400, 50, -1, -1);
    rd_chk("ctrl_done", 12'h000, 32'h6);
    rd_chk("ctrl_clr", 12'h000, 32'h4);

    cf[0] = 1; cf[1] = 2; cf[2] = 3; cf[3] = 4;
    prog(4, 6);
    xs[0] = 1;
    for (int i = 1; i < 6; i++) xs[i] = 0;
    lw(12'h000, 1);
    run(6, -1, 2, -1);
    rd_chk("busy_coef", 12'h080, 1);
    rd_chk("busy_len", 12'h010, 6);
    rd_chk("imp_done", 12'h000, 32'h6);
    rd_chk("imp_clr", 12'h000, 32'h4);

    cf[0] = 32'h7FFFFFFF;
    prog(1, 1);
    xs[0] = 2;
    lw(12'h000, 1);
    run(1, -1, -1, -1);
    check("wrap_model", ref_y(0), 32'hFFFFFFFE);
    rd_chk("wrap_done", 12'h000, 32'h6);

    lw(12'h010, 0);
    lw(12'h000, 1);
    check("len0_sm", 32'(sm_tvalid), 0);
    check("len0_ss", 32'(ss_tready), 0);
    rd_chk("len0_done", 12'h000, 32'h6);
    rd_chk("len0_clr", 12'h000, 32'h4);

    for (int j = 0; j < 32; j++)
      cf[j] = int'($urandom);
    prog(32, 400);
    for (int i = 0; i < 400; i++) xs[i] = int'($urandom);
    lw(12'h000, 1);
    run(400, -1, -1, 100);
    #2 rst_n = 0;
    #1;
    check("arst_sm_tvalid", 32'(sm_tvalid), 0);
    check("arst_ss_tready", 32'(ss_tready), 0);
    @(negedge clk) rst_n = 1;
    rd_chk("arst_ctrl", 12'h000, 32'h4);
    rd_chk("arst_tap", 12'h014, 0);
    rd_chk("arst_coef", 12'h08C, 0);
    prog(32, 400);
    lw(12'h000, 1);
    run(400, -1, -1, -1);
    rd_chk("rerun_done", 12'h000, 32'h6);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
